// File: rtl/alu_opcollect_core_if.sv
// Driver-facing bundle for alu_opcollect_core.
//   master : the driver side (operands, command, qualifiers out; results in)
//   slave  : the ALU core side
// Signals: CE, MODE, CMD[3:0], OPA/OPB[W-1:0], INP_VALID[1:0], CIN (driver -> core)
//          RES[2W-1:0], RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY (core -> driver)
interface alu_opcollect_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      CE;
  logic                      MODE;
  logic [3:0]                CMD;
  logic [DATA_WIDTH-1:0]     OPA;
  logic [DATA_WIDTH-1:0]     OPB;
  logic [1:0]                INP_VALID;
  logic                      CIN;
  logic [2*DATA_WIDTH-1:0]   RES;
  logic                      RES_VALID;
  logic                      COUT;
  logic                      OFLOW;
  logic                      G;
  logic                      L;
  logic                      E;
  logic                      ERR;
  logic                      BUSY;

  modport master (
    output CE, MODE, CMD, OPA, OPB, INP_VALID, CIN,
    input  RES, RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY
  );

  modport slave (
    input  CE, MODE, CMD, OPA, OPB, INP_VALID, CIN,
    output RES, RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY
  );
endinterface

// File: rtl/alu_opcollect_core.sv
// Parametrised ALU core with operand collection.
// Operands may arrive on different cycles; a two-operand command waits up to
// WAIT_CYCLES enabled cycles for the missing one before reporting ERR.
// Multiplies take one extra cycle with BUSY asserted. All outputs registered.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - alu_opcollect_core_if.slave: CE, MODE, CMD, OPA, OPB, INP_VALID, CIN in;
//          RES, RES_VALID, COUT, OFLOW, G, L, E, ERR, BUSY out
module alu_opcollect_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  alu_opcollect_core_if.slave bus
);
  localparam int W   = DATA_WIDTH;
  localparam int LW  = $clog2(DATA_WIDTH);
  localparam int LW1 = LW + 1;
  localparam int TW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST  = TW'(WAIT_CYCLES - 1);
  localparam logic [LW:0]   WLEN   = LW1'(DATA_WIDTH);
  localparam logic [W:0]    ONE_W1 = {{W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL} state_t;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           l;
    logic           e;
    logic           err;
  } result_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            cin_q, cin_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [1:0]      have_q, have_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2*W-1:0]  res_q, res_d;
  logic            cout_q, cout_d;
  logic            oflow_q, oflow_d;
  logic            g_q, g_d;
  logic            l_q, l_d;
  logic            e_q, e_d;
  logic            err_q, err_d;
  logic            rv_q, rv_d;
  logic            busy_q, busy_d;

  // Effective command/operands: in WAIT the latched command is used and any
  // operand arriving now replaces the latched copy.
  logic            in_wait;
  logic            mode_e;
  logic [3:0]      cmd_e;
  logic            cin_e;
  logic [W-1:0]    a_e;
  logic [W-1:0]    b_e;
  logic [1:0]      have_e;

  assign in_wait = (state_q == S_WAIT);
  assign mode_e  = in_wait ? mode_q : bus.MODE;
  assign cmd_e   = in_wait ? cmd_q  : bus.CMD;
  assign cin_e   = in_wait ? cin_q  : bus.CIN;
  assign a_e     = bus.INP_VALID[0] ? bus.OPA : a_q;
  assign b_e     = bus.INP_VALID[1] ? bus.OPB : b_q;
  assign have_e  = (in_wait ? have_q : 2'b00) | bus.INP_VALID;

  // Single-cycle execution unit
  logic [W:0]      ar;
  logic            ar_used;
  logic [W-1:0]    lr;
  logic [LW-1:0]   amt;
  logic [LW:0]     amt_inv;
  logic            rot_bad;
  logic [1:0]      need_e;
  logic            mul_e;
  result_t         ex;

  always_comb begin
    ex      = '0;
    ar      = '0;
    ar_used = 1'b0;
    lr      = '0;
    need_e  = 2'b11;
    mul_e   = 1'b0;
    amt     = b_e[LW-1:0];
    amt_inv = WLEN - {1'b0, amt};
    rot_bad = |(b_e >> LW);
    if (mode_e) begin
      ar_used = (cmd_e <= 4'd7);
      case (cmd_e)
        4'd0:  ar = {1'b0, a_e} + {1'b0, b_e};
        4'd1:  ar = {1'b0, a_e} - {1'b0, b_e};
        4'd2:  ar = {1'b0, a_e} + {1'b0, b_e} + {{W{1'b0}}, cin_e};
        4'd3:  ar = {1'b0, a_e} - {1'b0, b_e} - {{W{1'b0}}, cin_e};
        4'd4:  begin ar = {1'b0, a_e} + ONE_W1; need_e = 2'b01; end
        4'd5:  begin ar = {1'b0, a_e} - ONE_W1; need_e = 2'b01; end
        4'd6:  begin ar = {1'b0, b_e} + ONE_W1; need_e = 2'b10; end
        4'd7:  begin ar = {1'b0, b_e} - ONE_W1; need_e = 2'b10; end
        4'd8:  begin
          ex.g = (a_e > b_e);
          ex.l = (a_e < b_e);
          ex.e = (a_e == b_e);
        end
        4'd9, 4'd10: mul_e = 1'b1;
        default: begin need_e = 2'b00; ex.err = 1'b1; end
      endcase
      if (ar_used) begin
        ex.res  = {{(W-1){1'b0}}, ar};
        ex.cout = ar[W];
        // odd opcodes 1,3,5,7 are the subtract/decrement family; bit W is the borrow
        ex.oflow = cmd_e[0] & ar[W];
      end
    end else begin
      case (cmd_e)
        4'd0:  lr = a_e & b_e;
        4'd1:  lr = ~(a_e & b_e);
        4'd2:  lr = a_e | b_e;
        4'd3:  lr = ~(a_e | b_e);
        4'd4:  lr = a_e ^ b_e;
        4'd5:  lr = ~(a_e ^ b_e);
        4'd6:  begin lr = ~a_e;      need_e = 2'b01; end
        4'd7:  begin lr = ~b_e;      need_e = 2'b10; end
        4'd8:  begin lr = a_e >> 1;  need_e = 2'b01; end
        4'd9:  begin lr = a_e << 1;  need_e = 2'b01; end
        4'd10: begin lr = b_e >> 1;  need_e = 2'b10; end
        4'd11: begin lr = b_e << 1;  need_e = 2'b10; end
        // a shift by W yields 0, so amt=0 leaves A unchanged
        4'd12: if (rot_bad) ex.err = 1'b1;
               else lr = (a_e << amt) | (a_e >> amt_inv);
        4'd13: if (rot_bad) ex.err = 1'b1;
               else lr = (a_e >> amt) | (a_e << amt_inv);
        default: begin need_e = 2'b00; ex.err = 1'b1; end
      endcase
      ex.res = {{W{1'b0}}, lr};
    end
  end

  // Multiply path works from the operands latched on entry to MUL
  logic [W:0]     mx;
  logic [W:0]     my;
  logic [2*W-1:0] prod;

  always_comb begin
    if (cmd_q == 4'd9) begin
      mx = {1'b0, a_q} + ONE_W1;
      my = {1'b0, b_q} + ONE_W1;
    end else begin
      mx = {a_q, 1'b0};
      my = {1'b0, b_q};
    end
    prod = {{(W-1){1'b0}}, mx} * {{(W-1){1'b0}}, my};
  end

  // Next-state / output logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    have_d  = have_q;
    timer_d = timer_q;
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    err_d   = 1'b0;
    rv_d    = 1'b0;
    busy_d  = busy_q;
    if (bus.CE) begin
      case (state_q)
        S_IDLE, S_WAIT: begin
          // IDLE and WAIT share the collection logic; IDLE only acts when
          // something arrives, and only WAIT counts towards the timeout.
          if (in_wait || (bus.INP_VALID != 2'b00)) begin
            if ((need_e & ~have_e) == 2'b00) begin
              have_d = 2'b00;
              if (mul_e) begin
                state_d = S_MUL;
                busy_d  = 1'b1;
                mode_d  = mode_e;
                cmd_d   = cmd_e;
                a_d     = a_e;
                b_d     = b_e;
              end else begin
                state_d = S_IDLE;
                rv_d    = 1'b1;
                {res_d, cout_d, oflow_d, g_d, l_d, e_d, err_d} = ex;
              end
            end else if (in_wait && (timer_q == TLAST)) begin
              state_d = S_IDLE;
              have_d  = 2'b00;
              rv_d    = 1'b1;
              err_d   = 1'b1;
              res_d   = '0;
              cout_d  = 1'b0;
              oflow_d = 1'b0;
              g_d     = 1'b0;
              l_d     = 1'b0;
              e_d     = 1'b0;
            end else begin
              state_d = S_WAIT;
              mode_d  = mode_e;
              cmd_d   = cmd_e;
              cin_d   = cin_e;
              a_d     = a_e;
              b_d     = b_e;
              have_d  = have_e;
              timer_d = in_wait ? (timer_q + TW'(1)) : '0;
            end
          end
        end
        S_MUL: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rv_d    = 1'b1;
          res_d   = prod;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      have_q  <= '0;
      timer_q <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      have_q  <= have_d;
      timer_q <= timer_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.RES       = res_q;
  assign bus.RES_VALID = rv_q;
  assign bus.COUT      = cout_q;
  assign bus.OFLOW     = oflow_q;
  assign bus.G         = g_q;
  assign bus.L         = l_q;
  assign bus.E         = e_q;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = busy_q;
endmodule
